// File: rtl/request_encoder_pkg.sv
// Shared constants for the request encoder slice.
//   IDX_W     : width of the encoded line index
//   NUM_LINES : number of request lines (2**IDX_W)
//   state_t   : presentation FSM states (IDLE: valid=0, PRESENT: valid=1)
package encoder_pkg;

    localparam int IDX_W     = 2;
    localparam int NUM_LINES = 1 << IDX_W;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/request_encoder_if.sv
// Handshake/bus bundle of the request encoder.
//   enable        : permits a new selection (never aborts a presented code)
//   req0..req3    : request lines, latched as pending when sampled high
//   ready         : consumer accepts the presented code when valid=1
//   addr0, addr1  : encoded index of the granted line, {addr1,addr0}
//   valid         : addr holds a granted index awaiting acceptance
//   pend0..pend3  : registered pending flag per line
// master: request/consumer side; slave: the encoder itself.
interface request_encoder_if;

    logic enable;
    logic req0;
    logic req1;
    logic req2;
    logic req3;
    logic ready;
    logic addr0;
    logic addr1;
    logic valid;
    logic pend0;
    logic pend1;
    logic pend2;
    logic pend3;

    modport master (
        output enable, req0, req1, req2, req3, ready,
        input  addr0, addr1, valid, pend0, pend1, pend2, pend3
    );

    modport slave (
        input  enable, req0, req1, req2, req3, ready,
        output addr0, addr1, valid, pend0, pend1, pend2, pend3
    );

endinterface

// File: rtl/request_encoder_pick.sv
// encoder_pick: combinational index selection.
//   pend  : pending vector, one bit per line
//   start : line index the search begins at (wraps past the top line to 0)
//   idx   : first pending line found from start upward
//   any   : at least one line is pending
module encoder_pick
    import encoder_pkg::*;
(
    input  logic [NUM_LINES-1:0] pend,
    input  logic [IDX_W-1:0]     start,
    output logic [IDX_W-1:0]     idx,
    output logic                 any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int unsigned i = 0; i < NUM_LINES; i++) begin
            // Index arithmetic wraps modulo NUM_LINES through the IDX_W width.
            cand = start + IDX_W'(i);
            if (!any && pend[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/request_encoder.sv
// request_encoder: latches request lines as pending, picks one and presents
// its encoded index until the consumer accepts it, then clears that line.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (clears state, code and pending)
//   bus   : request_encoder_if.slave handshake bundle
// Build option: define ROUND_ROBIN_EN to rotate the search start to the line
// after the last grant; otherwise fixed lowest-index priority applies.
module request_encoder
    import encoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    request_encoder_if.slave  bus
);

    state_t                 state_q, state_n;
    logic [IDX_W-1:0]       addr_q, addr_n;
    logic [NUM_LINES-1:0]   pend_q, pend_n;
    logic [NUM_LINES-1:0]   req_v;
    logic [IDX_W-1:0]       start;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   grant;

    assign req_v = {bus.req3, bus.req2, bus.req1, bus.req0};

    encoder_pick u_pick (
        .pend  (pend_q),
        .start (start),
        .idx   (pick_idx),
        .any   (pick_any)
    );

`ifdef ROUND_ROBIN_EN
    // Last-granted pointer; reset to the top line so the first search
    // begins at line 0.
    logic [IDX_W-1:0] last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '1;
        end else if (grant) begin
            last_q <= pick_idx;
        end
    end

    assign start = last_q + 1'b1;
`else
    assign start = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_n;
            addr_q  <= addr_n;
            pend_q  <= pend_n;
        end
    end

    always_comb begin
        state_n = state_q;
        addr_n  = addr_q;
        pend_n  = pend_q | req_v;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable && pick_any) begin
                    grant   = 1'b1;
                    addr_n  = pick_idx;
                    state_n = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.ready) begin
                    // A request on the accepted line in the same edge wins.
                    pend_n[addr_q] = req_v[addr_q];
                    state_n        = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.addr0 = addr_q[0];
    assign bus.addr1 = addr_q[1];
    assign bus.valid = (state_q == PRESENT);
    assign bus.pend0 = pend_q[0];
    assign bus.pend1 = pend_q[1];
    assign bus.pend2 = pend_q[2];
    assign bus.pend3 = pend_q[3];

endmodule

// File: tb/tb_request_encoder.sv
// Testbench for request_encoder: a behavioural model (pending set, busy flag,
// presented code, last grant) runs beside the DUT and is compared every
// cycle; directed scenarios pin the model with literal expectations, then a
// randomized phase exercises the rest. Honours ROUND_ROBIN_EN like the DUT.
module tb_request_encoder;

    logic clk;
    logic rst_n;

    request_encoder_if bus ();

    request_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    // ---------------- behavioural model ----------------
    int m_pend [4];
    bit m_busy;
    int m_code;
    int m_last;
    bit [3:0] m_req;
    int m_g;

    function automatic int m_pick();
        int s;
`ifdef ROUND_ROBIN_EN
        s = (m_last + 1) % 4;
`else
        s = 0;
`endif
        for (int k = 0; k < 4; k++) begin
            if (m_pend[(s + k) % 4] != 0) return (s + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_pend[i] = 0;
            m_busy = 1'b0;
            m_code = 0;
            m_last = 3;
        end else begin
            m_req = {bus.req3, bus.req2, bus.req1, bus.req0};
            if (m_busy) begin
                if (bus.ready) begin
                    m_pend[m_code] = 0;
                    m_busy = 1'b0;
                end
            end else if (bus.enable) begin
                m_g = m_pick();
                if (m_g >= 0) begin
                    m_code = m_g;
                    m_last = m_g;
                    m_busy = 1'b1;
                end
            end
            for (int i = 0; i < 4; i++) if (m_req[i]) m_pend[i] = 1;
        end
    end

    function automatic int dut_code();
        return int'({bus.addr1, bus.addr0});
    endfunction

    function automatic int dut_pend();
        return int'({bus.pend3, bus.pend2, bus.pend1, bus.pend0});
    endfunction

    function automatic int model_pend();
        int v;
        v = 0;
        for (int i = 0; i < 4; i++) if (m_pend[i] != 0) v = v | (1 << i);
        return v;
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        tests++;
        if (bus.valid !== m_busy || dut_code() != m_code || dut_pend() != model_pend()) begin
            fails++;
            $display("FAIL model t=%0t: got valid=%0b addr=%0d pend=%04b, want valid=%0b addr=%0d pend=%04b",
                     $time, bus.valid, dut_code(), dut_pend()[3:0], m_busy, m_code, model_pend()[3:0]);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s t=%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input bit [3:0] r);
        bus.req0 = r[0];
        bus.req1 = r[1];
        bus.req2 = r[2];
        bus.req3 = r[3];
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_valid", int'(bus.valid), 0);
        chk("reset_addr", dut_code(), 0);
        chk("reset_pend", dut_pend(), 0);
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    int exp_seq [5];

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        bus.enable = 1'b0;
        bus.ready  = 1'b0;
        set_req(4'b0000);
        #2;
        do_reset();

        // Single request on line 2.
        bus.enable = 1'b1;
        bus.ready  = 1'b1;
        set_req(4'b0100);
        cyc();
        set_req(4'b0000);
        chk("r2_pend_set", dut_pend(), 4'b0100);
        chk("r2_not_yet_valid", int'(bus.valid), 0);
        cyc();
        chk("r2_valid", int'(bus.valid), 1);
        chk("r2_addr", dut_code(), 2);
        cyc();
        chk("r2_accepted_valid", int'(bus.valid), 0);
        chk("r2_accepted_pend", dut_pend(), 0);

        // Lines 0 and 3 together: 0 then 3 with a bubble.
        do_reset();
        set_req(4'b1001);
        cyc();
        set_req(4'b0000);
        cyc();
        chk("r03_first_valid", int'(bus.valid), 1);
        chk("r03_first_addr", dut_code(), 0);
        cyc();
        chk("r03_bubble", int'(bus.valid), 0);
        chk("r03_bubble_pend", dut_pend(), 4'b1000);
        cyc();
        chk("r03_second_valid", int'(bus.valid), 1);
        chk("r03_second_addr", dut_code(), 3);
        cyc();
        chk("r03_done_pend", dut_pend(), 0);

        // Stall with code 01, line 0 requested meanwhile.
        do_reset();
        bus.ready = 1'b0;
        set_req(4'b0010);
        cyc();
        set_req(4'b0000);
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", int'(bus.valid), 1);
            chk("stall_addr", dut_code(), 1);
            set_req(i == 1 ? 4'b0001 : 4'b0000);
            cyc();
        end
        bus.ready = 1'b1;
        cyc();
        chk("stall_after_accept_valid", int'(bus.valid), 0);
        chk("stall_after_accept_pend", dut_pend(), 4'b0001);
        cyc();
        chk("stall_next_addr", dut_code(), 0);
        chk("stall_next_valid", int'(bus.valid), 1);

        // enable low blocks selection.
        do_reset();
        bus.enable = 1'b0;
        bus.ready  = 1'b0;
        set_req(4'b0010);
        cyc();
        set_req(4'b0000);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("en_low_valid", int'(bus.valid), 0);
        end
        chk("en_low_pend", dut_pend(), 4'b0010);
        bus.enable = 1'b1;
        cyc();
        chk("en_high_valid", int'(bus.valid), 1);
        chk("en_high_addr", dut_code(), 1);

        // Asynchronous reset mid-presentation.
        set_req(4'b1100);
        cyc();
        set_req(4'b0000);
        chk("pre_rst_valid", int'(bus.valid), 1);
        chk("pre_rst_pend", dut_pend(), 4'b1110);
        #1;
        do_reset();

        // All four lines held high.
        bus.enable = 1'b1;
        bus.ready  = 1'b1;
        set_req(4'b1111);
`ifdef ROUND_ROBIN_EN
        exp_seq = '{0, 1, 2, 3, 0};
`else
        exp_seq = '{0, 0, 0, 0, 0};
`endif
        cyc();
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("all4_valid", int'(bus.valid), 1);
            chk("all4_addr", dut_code(), exp_seq[i]);
            cyc();
            chk("all4_bubble", int'(bus.valid), 0);
            chk("all4_pend_kept", dut_pend(), 4'b1111);
        end
        set_req(4'b0000);

        // Randomized phase, checked by the per-cycle model comparison.
        for (int n = 0; n < 3000; n++) begin
            bus.enable = ($urandom_range(0, 3) != 0);
            bus.ready  = ($urandom_range(0, 1) != 0);
            for (int i = 0; i < 4; i++) begin
                case (i)
                    0: bus.req0 = ($urandom_range(0, 4) == 0);
                    1: bus.req1 = ($urandom_range(0, 4) == 0);
                    2: bus.req2 = ($urandom_range(0, 4) == 0);
                    default: bus.req3 = ($urandom_range(0, 4) == 0);
                endcase
            end
            if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            cyc();
        end
        rst_n = 1'b1;
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/request_encoder.md
REQUEST_ENCODER -- requirements
Module: request_encoder

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 enable  input  1  permits a new selection; never aborts a presented code.
REQ-004 req0..req3  input  1 each  request lines; a 1 sampled at a clk edge latches the line as pending.
REQ-005 ready  input  1  consumer accepts the presented code on a clk edge where valid=1 and ready=1.
REQ-006 addr0  output  1  LSB of the encoded index of the granted line.
REQ-007 addr1  output  1  MSB of the encoded index; index = {addr1,addr0}.
REQ-008 valid  output  1  addr0/addr1 hold a granted index awaiting acceptance.
REQ-009 pend0..pend3  output  1 each  registered pending flag per request line.

Function
REQ-010 The block SHALL be the inverse of the 2-to-4 decoder: it encodes line i to {addr1,addr0} = i, so that decoding the code with enable=1 asserts out_i only.
REQ-011 Each pend_i SHALL set on any edge where req_i=1, and hold until cleared by acceptance.
REQ-012 The FSM SHALL have two states: IDLE (valid=0) and PRESENT (valid=1).
REQ-013 In IDLE with enable=1 and any pend_i=1, the next edge SHALL register the selected index into addr1/addr0 and enter PRESENT; latency from req to valid is 2 edges.
REQ-014 In IDLE with enable=0 or no pending line, the block SHALL stay in IDLE with addr outputs unchanged.
REQ-015 The default selection SHALL be fixed priority, lowest index wins.
REQ-016 In PRESENT, addr1/addr0 SHALL remain stable until acceptance, regardless of req, pend or enable activity.
REQ-017 On acceptance the block SHALL clear the granted pend_i and return to IDLE, giving one bubble cycle between consecutive grants.
REQ-018 If req_i=1 on the acceptance edge of line i, the set SHALL win and pend_i stays 1.
REQ-019 Requests to an already-pending line SHALL merge; no count is kept.
REQ-020 Deasserting enable in PRESENT SHALL NOT drop valid; the block blocks only the next selection.

Reset
REQ-021 rst_n=0 SHALL immediately force IDLE, valid=0, addr0=0, addr1=0 and all pend_i=0, including mid-presentation.
REQ-022 The first selection after release SHALL need a fresh req sample, because pending state is not retained.

Configuration
REQ-023 With ROUND_ROBIN_EN defined, selection SHALL start from (last granted index + 1) mod 4 and wrap 3->0.
REQ-024 Under ROUND_ROBIN_EN, the last-granted pointer SHALL reset to 3, so the first search starts at line 0.
REQ-025 Without ROUND_ROBIN_EN, fixed lowest-index priority SHALL apply and no pointer register SHALL exist.

Structure
REQ-026 A shared package encoder_pkg SHALL hold the state encoding constants (IDLE, PRESENT) and the index width constant (2).
REQ-027 Index selection SHALL be a combinational sub-module encoder_pick: pending vector plus start pointer in, index plus any-flag out.
REQ-028 The FSM, pending registers and output registers SHALL reside in request_encoder.

Verification
REQ-029 req2=1 for one cycle, ready=1, enable=1 -> valid rises 2 edges later with {addr1,addr0}=10, held 1 cycle, then pend2=0.
REQ-030 req0=req3=1 together, ready=1 -> grants 00 then 11 (bubble between); under ROUND_ROBIN_EN the same order.
REQ-031 ready=0 for 5 cycles while valid=1 with code 01, req0 pulsed meanwhile -> code stays 01; after acceptance the next grant is 00.
REQ-032 enable=0 with pend1=1 -> valid stays 0; enable=1 -> code 01 presented 1 edge later.
REQ-033 rst_n=0 asserted mid-PRESENT between edges -> valid=0, addr=00 and pend=0000 without waiting for clk.
REQ-034 ROUND_ROBIN_EN with all four req held at 1 -> grant sequence 00,01,10,11,00; fixed-priority build -> 00 repeated.
